word_serializer: RTL and testbench

- Parallel-in, serial-out transmitter. It is the sending end for the team's 16-bit serial shift registers.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts each word out one bit per bit-enable strobe, LSB-first or MSB-first per word.
- A one-entry holding buffer lets back-to-back words go out with no idle bit slot between frames.
- Sits between a parallel producer and any serial-in shift register or link.

---
 rtl/word_serializer.sv | 135 +++++++++++++
 tb/tb_word_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// word_serializer: parallel-in, serial-out transmitter with a one-entry
// holding buffer so consecutive words leave with no idle bit slot between them.
module word_serializer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_right,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             dir_q, dir_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_dir_q, hold_dir_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q;
  logic             accept_c;
  logic             last_c;
  logic             ser_out_d, ser_valid_d, frame_start_d, busy_d;

  // Ready comes from a register; reset only masks it so no word is taken while reset is held.
  assign load_ready = ready_q & ~reset;
  assign accept_c   = load_valid & load_ready;
  assign last_c     = (state_q == SHIFT) && ser_en && (count_q == LAST_IDX);

  // Next-state logic: frame sequencing, holding-buffer management and output decode.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    dir_d       = dir_q;
    count_d     = count_q;
    hold_d      = hold_q;
    hold_dir_d  = hold_dir_q;
    hold_full_d = hold_full_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          shift_d = data_in;
          dir_d   = shift_right;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ser_en) begin
          if (count_q == LAST_IDX) begin
            if (hold_full_q) begin
              shift_d     = hold_q;
              dir_d       = hold_dir_q;
              count_d     = '0;
              hold_full_d = 1'b0;
            end else if (accept_c) begin
              shift_d = data_in;
              dir_d   = shift_right;
              count_d = '0;
            end else begin
              shift_d = '0;
              count_d = '0;
              state_d = IDLE;
            end
          end else begin
            shift_d = dir_q ? {1'b0, shift_q[WIDTH-1:1]} : {shift_q[WIDTH-2:0], 1'b0};
            count_d = count_q + CW'(1);
          end
        end
        // A word arriving mid-frame waits in the buffer unless it can follow directly.
        if (accept_c && !last_c) begin
          hold_d      = data_in;
          hold_dir_d  = shift_right;
          hold_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ser_valid_d   = (state_d == SHIFT);
    ser_out_d     = ser_valid_d & (dir_d ? shift_d[0] : shift_d[WIDTH-1]);
    frame_start_d = (state_d == SHIFT) && (count_d == '0);
    busy_d        = (state_d == SHIFT) || hold_full_d;
  end

  // State and registered-output update; synchronous reset aborts any frame and drops the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      dir_q       <= 1'b0;
      count_q     <= '0;
      hold_q      <= '0;
      hold_dir_q  <= 1'b0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      dir_q       <= dir_d;
      count_q     <= count_d;
      hold_q      <= hold_d;
      hold_dir_q  <= hold_dir_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ~hold_full_d;
      ser_out     <= ser_out_d;
      ser_valid   <= ser_valid_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
      done        <= last_c;
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// tb_word_serializer: scenario tasks against a word-queue reference model.
module tb_word_serializer;

  localparam int unsigned W = 16;

  logic         clk;
  logic         reset;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] data_in;
  logic         shift_right;
  logic         ser_en;
  logic         ser_out;
  logic         ser_valid;
  logic         frame_start;
  logic         busy;
  logic         done;
  logic [5:0]   obs;

  int checks   = 0;
  int failures = 0;

  // Reference model: words still owed to the line (head is in flight), bit index of head.
  logic [W:0] mq[$];
  int          mpos  = 0;
  logic        mdone = 1'b0;
  logic        ebits[$];
  logic        rx[$];

  word_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .data_in(data_in), .shift_right(shift_right), .ser_en(ser_en), .ser_out(ser_out),
    .ser_valid(ser_valid), .frame_start(frame_start), .busy(busy), .done(done)
  );

  assign obs = {ser_valid, ser_out, frame_start, busy, done, load_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit currently owed on the line by the model.
  function automatic logic head_bit();
    logic [W:0] h;
    if (mq.size() == 0) return 1'b0;
    h = mq[0];
    return h[W] ? h[mpos] : h[int'(W) - 1 - mpos];
  endfunction

  // Expected {ser_valid, ser_out, frame_start, busy, done, load_ready}.
  function automatic logic [5:0] exp_vec();
    logic v;
    v = (mq.size() != 0);
    return {v, head_bit(), v && (mpos == 0), v, mdone, !reset && (mq.size() < 2)};
  endfunction

  // Advance one clock, updating the model with what was presented before the edge.
  task automatic tick();
    logic acc, en, rst, s;
    logic [W-1:0] d;
    rst = reset; en = ser_en; d = data_in; s = shift_right;
    acc = load_valid && !rst && (mq.size() < 2);
    if (!rst && ser_valid && ser_en) rx.push_back(ser_out);
    @(posedge clk);
    if (rst) begin
      mq.delete(); mpos = 0; mdone = 1'b0;
    end else begin
      mdone = 1'b0;
      if (mq.size() > 0 && en) begin
        ebits.push_back(head_bit());
        mpos++;
        if (mpos == int'(W)) begin
          void'(mq.pop_front());
          mpos  = 0;
          mdone = 1'b1;
        end
      end
      if (acc) mq.push_back({s, d});
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; data_in = '0; shift_right = 1'b0; ser_en = 1'b0;
    tick(); tick();
    checks++;
    if (obs !== 6'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=000000", obs); end
    load_valid = 1'b1; data_in = 16'hFFFF; ser_en = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b0) begin failures++; $display("FAIL reset_wins got=%b exp=000000", obs); end
    load_valid = 1'b0; reset = 1'b0;
    #1;
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", load_ready); end
  endtask

  task automatic test_single(input logic [W-1:0] word, input logic dir, input logic [W-1:0] seq, input string tag);
    int nd, nfs;
    nd = 0; nfs = 0;
    ser_en = 1'b1; load_valid = 1'b1; data_in = word; shift_right = dir;
    tick();
    load_valid = 1'b0; shift_right = ~dir; data_in = W'($urandom);
    for (int i = 0; i < 18; i++) begin
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL %s_cyc%0d got=%b exp=%b", tag, i, obs, exp_vec()); end
      if (i < 16) begin
        checks++;
        if (ser_out !== seq[15-i]) begin failures++; $display("FAIL %s_bit%0d got=%b exp=%b", tag, i, ser_out, seq[15-i]); end
      end
      if (done) nd++;
      if (frame_start) nfs++;
      if (i == 0 || i == 15) begin
        checks++;
        if (frame_start !== (i == 0)) begin failures++; $display("FAIL %s_fs%0d got=%b", tag, i, frame_start); end
      end
      tick();
    end
    checks++;
    if (nd != 1 || nfs != 1) begin failures++; $display("FAIL %s_pulses done=%0d fs=%0d exp=1/1", tag, nd, nfs); end
    checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL %s_idle valid=%b busy=%b exp=0/0", tag, ser_valid, busy); end
  endtask

  task automatic test_back_to_back();
    int nv, nd, fs0, fs1, run, maxrun;
    nv = 0; nd = 0; fs0 = -1; fs1 = -1; run = 0; maxrun = 0;
    ser_en = 1'b1; load_valid = 1'b1; data_in = 16'h0001; shift_right = 1'b1;
    for (int c = 0; c < 36; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL b2b_cyc%0d got=%b exp=%b", c, obs, exp_vec()); end
      if (ser_valid) begin
        run++;
        if (run > maxrun) maxrun = run;
        checks++;
        if (ser_out !== (nv % 16 == 0)) begin failures++; $display("FAIL b2b_bit%0d got=%b", nv, ser_out); end
        nv++;
      end else run = 0;
      if (done) nd++;
      if (frame_start) begin if (fs0 < 0) fs0 = c; else fs1 = c; end
      if (c == 0) begin data_in = 16'h8000; shift_right = 1'b0; end
      if (c == 1) load_valid = 1'b0;
    end
    checks++;
    if (maxrun != 32) begin failures++; $display("FAIL b2b_valid_run got=%0d exp=32", maxrun); end
    checks++;
    if (nd != 2) begin failures++; $display("FAIL b2b_done got=%0d exp=2", nd); end
    checks++;
    if (fs1 - fs0 != 16) begin failures++; $display("FAIL b2b_fs_spacing got=%0d exp=16", fs1 - fs0); end
  endtask

  task automatic test_backpressure();
    logic [W:0] words[3];
    logic       exp_stream[$];
    int k, nd;
    logic acc_now;
    k = 0; nd = 0;
    rx.delete();
    for (int j = 0; j < 3; j++) words[j] = {1'($urandom), W'($urandom)};
    for (int j = 0; j < 3; j++)
      for (int b = 0; b < int'(W); b++)
        exp_stream.push_back(words[j][W] ? words[j][b] : words[j][int'(W) - 1 - b]);
    for (int c = 0; c < 400 && nd < 3; c++) begin
      ser_en = (c % 3 == 2);
      if (k < 3) begin load_valid = 1'b1; {shift_right, data_in} = words[k]; end
      else load_valid = 1'b0;
      acc_now = load_valid && (mq.size() < 2);
      tick();
      if (acc_now) k++;
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL bp_cyc%0d got=%b exp=%b", c, obs, exp_vec()); end
      if (done) nd++;
    end
    load_valid = 1'b0;
    checks++;
    if (nd != 3) begin failures++; $display("FAIL bp_frames got=%0d exp=3", nd); end
    checks++;
    if (rx != exp_stream) begin failures++; $display("FAIL bp_stream got_len=%0d exp_len=%0d", rx.size(), exp_stream.size()); end
  endtask

  task automatic test_reset_mid();
    ser_en = 1'b1; load_valid = 1'b1; data_in = 16'hFFFF; shift_right = 1'b1;
    tick();
    data_in = W'($urandom) | 16'h0101; shift_right = 1'($urandom);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (obs !== exp_vec() || busy !== 1'b1) begin failures++; $display("FAIL rmid_pre got=%b exp=%b", obs, exp_vec()); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (ser_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", ser_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL rmid_done got=%b exp=0", done); end
    checks++;
    if (load_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", load_ready); end
    for (int i = 0; i < 40; i++) begin
      tick();
      checks++;
      if (ser_valid !== 1'b0 || obs !== exp_vec()) begin failures++; $display("FAIL rmid_quiet%0d got=%b exp=%b", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_idle_gap();
    logic [W-1:0] w2;
    int seen;
    seen = 0;
    w2 = 16'h1234;
    ser_en = 1'b1; load_valid = 1'b1; data_in = W'($urandom); shift_right = 1'($urandom);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL gap_first%0d got=%b exp=%b", i, obs, exp_vec()); end
      if (done) seen = 1; else tick();
    end
    checks++;
    if (seen == 0) begin failures++; $display("FAIL gap_done_timeout got=0 exp=1"); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ser_out !== 1'b0 || ser_valid !== 1'b0) begin failures++; $display("FAIL gap_idle%0d out=%b valid=%b exp=0/0", i, ser_out, ser_valid); end
    end
    load_valid = 1'b1; data_in = w2; shift_right = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL gap_cyc%0d got=%b exp=%b", i, obs, exp_vec()); end
      if (i < 16) begin
        checks++;
        if (ser_out !== w2[i]) begin failures++; $display("FAIL gap_bit%0d got=%b exp=%b", i, ser_out, w2[i]); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    rx.delete(); ebits.delete();
    for (int c = 0; c < 800; c++) begin
      load_valid  = 1'($urandom_range(0, 1));
      data_in     = W'($urandom);
      shift_right = 1'($urandom);
      ser_en      = ($urandom_range(0, 9) < 7);
      tick();
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL rand_cyc%0d got=%b exp=%b", c, obs, exp_vec()); end
    end
    load_valid = 1'b0; ser_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin failures++; $display("FAIL rand_drain%0d got=%b exp=%b", c, obs, exp_vec()); end
    end
    checks++;
    if (rx != ebits) begin failures++; $display("FAIL rand_stream got_len=%0d exp_len=%0d", rx.size(), ebits.size()); end
  endtask

  initial begin
    test_reset();
    test_single(16'hA5C3, 1'b1, 16'b1100_0011_1010_0101, "lsb");
    test_single(16'hA5C3, 1'b0, 16'b1010_0101_1100_0011, "msb");
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_idle_gap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
